// File: rtl/arbitro_display_4d.sv
// Two-requester arbiter for a shared 4-digit 7-segment display.
// A grant is held for at least T_MIN+1 cycles. Ties from idle and handovers
// after the hold are decided round robin, using the last requester granted.
module arbitro_display_4d #(
  parameter int unsigned N_TMR = 24,
  parameter int unsigned T_MIN = 4999999
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Req_A,
  input  logic [15:0] i_Datos_A,
  input  logic        i_Req_B,
  input  logic [15:0] i_Datos_B,
  output logic        o_Gnt_A,
  output logic        o_Gnt_B,
  output logic        o_Ocupado,
  output logic [3:0]  o_Datos1,
  output logic [3:0]  o_Datos2,
  output logic [3:0]  o_Datos3,
  output logic [3:0]  o_Datos4
);

  localparam logic [N_TMR-1:0] TMin = N_TMR'(T_MIN);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntA = 2'd1,
    StGntB = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [N_TMR-1:0]  r_tmr;
  logic [N_TMR-1:0]  w_tmr_d;
  logic              r_ult;     // last requester granted: 0 = A, 1 = B
  logic              w_ult_d;
  logic [15:0]       r_datos;
  logic [15:0]       w_datos_d;
  logic              r_gnt_a;
  logic              r_gnt_b;
  logic              w_hold;

  assign w_hold = (r_tmr == TMin);

  // Next-state decision: idle arbitration, hold enforcement and handover.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_Req_A && i_Req_B) begin
          w_state_d = r_ult ? StGntA : StGntB;
        end else if (i_Req_A) begin
          w_state_d = StGntA;
        end else if (i_Req_B) begin
          w_state_d = StGntB;
        end
      end
      StGntA: begin
        if (w_hold) begin
          if (i_Req_B) begin
            w_state_d = StGntB;
          end else if (!i_Req_A) begin
            w_state_d = StIdle;
          end
        end
      end
      StGntB: begin
        if (w_hold) begin
          if (i_Req_A) begin
            w_state_d = StGntA;
          end else if (!i_Req_B) begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Timer, round-robin pointer and display data for the chosen next state.
  always_comb begin
    w_tmr_d   = r_tmr;
    w_ult_d   = r_ult;
    w_datos_d = r_datos;
    if (w_state_d == StGntA) begin
      if (r_state != StGntA) begin
        // Grant edge: new owner's digits appear together with the grant.
        w_tmr_d   = '0;
        w_ult_d   = 1'b0;
        w_datos_d = i_Datos_A;
      end else begin
        if (!w_hold) begin
          w_tmr_d = r_tmr + 1'b1;
        end
        if (i_Req_A) begin
          w_datos_d = i_Datos_A;
        end
      end
    end else if (w_state_d == StGntB) begin
      if (r_state != StGntB) begin
        w_tmr_d   = '0;
        w_ult_d   = 1'b1;
        w_datos_d = i_Datos_B;
      end else begin
        if (!w_hold) begin
          w_tmr_d = r_tmr + 1'b1;
        end
        if (i_Req_B) begin
          w_datos_d = i_Datos_B;
        end
      end
    end else begin
      // Idle: last digits stay on the display.
      w_tmr_d = '0;
    end
  end

  // State registers with synchronous reset; grants registered from next state.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state <= StIdle;
      r_tmr   <= '0;
      r_ult   <= 1'b1;
      r_datos <= 16'h0000;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_tmr   <= w_tmr_d;
      r_ult   <= w_ult_d;
      r_datos <= w_datos_d;
      r_gnt_a <= (w_state_d == StGntA);
      r_gnt_b <= (w_state_d == StGntB);
    end
  end

  assign o_Gnt_A   = r_gnt_a;
  assign o_Gnt_B   = r_gnt_b;
  assign o_Ocupado = r_gnt_a | r_gnt_b;
  assign o_Datos1  = r_datos[15:12];
  assign o_Datos2  = r_datos[11:8];
  assign o_Datos3  = r_datos[7:4];
  assign o_Datos4  = r_datos[3:0];

endmodule

// File: tb/tb_arbitro_display_4d.sv
// Directed bench for arbitro_display_4d with T_MIN=3 (4-cycle minimum grant).
module tb_arbitro_display_4d;

  logic        clk;
  logic        rst;
  logic        req_a;
  logic [15:0] datos_a;
  logic        req_b;
  logic [15:0] datos_b;
  logic        gnt_a;
  logic        gnt_b;
  logic        ocupado;
  logic [3:0]  d1, d2, d3, d4;

  int n_checks = 0;
  int n_errors = 0;

  arbitro_display_4d #(
    .N_TMR(4),
    .T_MIN(3)
  ) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Req_A  (req_a),
    .i_Datos_A(datos_a),
    .i_Req_B  (req_b),
    .i_Datos_B(datos_b),
    .o_Gnt_A  (gnt_a),
    .o_Gnt_B  (gnt_b),
    .o_Ocupado(ocupado),
    .o_Datos1 (d1),
    .o_Datos2 (d2),
    .o_Datos3 (d3),
    .o_Datos4 (d4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ra;
    logic [15:0] da;
    logic        rb;
    logic [15:0] db;
    logic        ega;
    logic        egb;
    logic        eoc;
    logic [15:0] ed;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic ra, input logic [15:0] da,
                     input logic rb, input logic [15:0] db,
                     input logic ega, input logic egb, input logic eoc,
                     input logic [15:0] ed);
    vec_t v;
    v.rst = r; v.ra = ra; v.da = da; v.rb = rb; v.db = db;
    v.ega = ega; v.egb = egb; v.eoc = eoc; v.ed = ed;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ra, input logic [15:0] da,
                       input logic rb, input logic [15:0] db);
    @(negedge clk);
    rst = r; req_a = ra; datos_a = da; req_b = rb; datos_b = db;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a_cycles;
    bit seen_b;
    bit gap;
    bit both;
    rst = 1'b1; req_a = 1'b0; datos_a = '0; req_b = 1'b0; datos_b = '0;

    //  rst ra  da       rb  db        gA  gB  oc  digits
    add(1, 0, 16'h0000, 0, 16'h0000,  0,  0,  0, 16'h0000); // reset
    add(1, 1, 16'h1234, 0, 16'h0000,  0,  0,  0, 16'h0000); // reset beats request
    add(0, 1, 16'h1234, 0, 16'h0000,  1,  0,  1, 16'h1234); // single request
    add(0, 1, 16'h5678, 0, 16'h0000,  1,  0,  1, 16'h5678); // live reload
    add(0, 0, 16'h9999, 0, 16'h0000,  1,  0,  1, 16'h5678); // freeze, still held
    add(0, 0, 16'h9999, 0, 16'h0000,  1,  0,  1, 16'h5678); // 4th grant cycle
    add(0, 0, 16'h9999, 0, 16'h0000,  0,  0,  0, 16'h5678); // release to idle
    add(0, 0, 16'h9999, 0, 16'h0000,  0,  0,  0, 16'h5678); // idle holds
    add(0, 1, 16'h1111, 1, 16'h2222,  0,  1,  1, 16'h2222); // tie, last was A
    add(0, 1, 16'h1111, 1, 16'h2323,  0,  1,  1, 16'h2323);
    add(0, 1, 16'h1111, 1, 16'h2323,  0,  1,  1, 16'h2323);
    add(0, 1, 16'h1111, 1, 16'h2323,  0,  1,  1, 16'h2323);
    add(0, 1, 16'h1111, 1, 16'h2323,  1,  0,  1, 16'h1111); // direct switch to A
    add(0, 1, 16'h1111, 1, 16'h2323,  1,  0,  1, 16'h1111);
    add(0, 1, 16'h1111, 1, 16'h2323,  1,  0,  1, 16'h1111);
    add(0, 1, 16'h1111, 1, 16'h2323,  1,  0,  1, 16'h1111);
    add(0, 1, 16'h1111, 1, 16'h2323,  0,  1,  1, 16'h2323); // back to B
    add(0, 1, 16'h1111, 1, 16'h2323,  0,  1,  1, 16'h2323);
    add(1, 1, 16'h1111, 1, 16'h2323,  0,  0,  0, 16'h0000); // reset mid-grant
    add(0, 1, 16'h1111, 1, 16'h2323,  1,  0,  1, 16'h1111); // A wins after reset
    add(0, 1, 16'h1111, 1, 16'h2323,  1,  0,  1, 16'h1111);
    add(0, 1, 16'h1111, 1, 16'h2323,  1,  0,  1, 16'h1111);
    add(0, 1, 16'h1111, 1, 16'h2323,  1,  0,  1, 16'h1111);
    add(0, 1, 16'h1111, 0, 16'h2323,  1,  0,  1, 16'h1111); // saturated, stays
    add(0, 0, 16'h1111, 1, 16'h4321,  0,  1,  1, 16'h4321); // B takes over
    add(0, 0, 16'h1111, 0, 16'h4321,  0,  1,  1, 16'h4321); // B held, frozen

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].ra, vq[i].da, vq[i].rb, vq[i].db);
      chk($sformatf("v%0d_gnt_a", i), 32'(gnt_a), 32'(vq[i].ega));
      chk($sformatf("v%0d_gnt_b", i), 32'(gnt_b), 32'(vq[i].egb));
      chk($sformatf("v%0d_ocupado", i), 32'(ocupado), 32'(vq[i].eoc));
      chk($sformatf("v%0d_datos", i), 32'({d1, d2, d3, d4}), 32'(vq[i].ed));
    end

    // Both requests raised together from reset: A for 4 cycles, then B, no gap.
    drive(1, 0, 16'h0000, 0, 16'h0000);
    chk("seq_reset_busy", 32'(ocupado), 32'd0);
    drive(0, 1, 16'hABCD, 1, 16'h0F0F);
    a_cycles = 0; seen_b = 0; gap = 0; both = 0;
    if (gnt_a) a_cycles++;
    for (int c = 0; c < 20 && !seen_b; c++) begin
      @(posedge clk);
      #1;
      if (gnt_a && gnt_b) both = 1;
      if (gnt_b) seen_b = 1;
      else if (gnt_a) a_cycles++;
      else gap = 1;
    end
    chk("seq_b_granted", 32'(seen_b), 32'd1);
    chk("seq_a_len", 32'(a_cycles), 32'd4);
    chk("seq_no_gap", 32'(gap), 32'd0);
    chk("seq_never_both", 32'(both), 32'd0);
    chk("seq_datos_b", 32'({d1, d2, d3, d4}), 32'h0F0F);

    // A dropped after one cycle with B idle: held 4 cycles, then idle, frozen.
    drive(1, 0, 16'h0000, 0, 16'h0000);
    drive(0, 1, 16'h2468, 0, 16'h0000);
    a_cycles = 0;
    if (gnt_a) a_cycles++;
    @(negedge clk);
    req_a = 1'b0; datos_a = 16'h7777;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (gnt_a) a_cycles++;
    end
    chk("drop_a_len", 32'(a_cycles), 32'd4);
    chk("drop_idle", 32'(ocupado), 32'd0);
    chk("drop_frozen", 32'({d1, d2, d3, d4}), 32'h2468);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arbitro_display_4d.md
ARBITRO_DISPLAY_4D -- requirements
Module: arbitro_display_4d

Interface
REQ-001 Parameter: N_TMR, 24, width of the hold timer; SHALL satisfy 2^N_TMR > T_MIN.
REQ-002 Parameter: T_MIN, 4999999, minimum grant hold in clock cycles, beyond the grant cycle.
REQ-003 Port: i_Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: i_Rst  input  1  reset, synchronous, active-high.
REQ-005 Port: i_Req_A  input  1  requester A wants the display.
REQ-006 Port: i_Datos_A  input  16  requester A digits; [15:12]=digit 1 ... [3:0]=digit 4.
REQ-007 Port: i_Req_B  input  1  requester B wants the display.
REQ-008 Port: i_Datos_B  input  16  requester B digits, same packing as A.
REQ-009 Port: o_Gnt_A  output  1  A owns the display.
REQ-010 Port: o_Gnt_B  output  1  B owns the display.
REQ-011 Port: o_Ocupado  output  1  o_Gnt_A OR o_Gnt_B.
REQ-012 Port: o_Datos1..o_Datos4  output  4 each  digit values driven into the 4-digit 7-segment display controller.

Function
REQ-013 FSM states SHALL be IDLE, GNT_A, GNT_B; o_Gnt_A/o_Gnt_B SHALL be registered decodes of GNT_A/GNT_B, never both high.
REQ-014 A 1-bit register ULT SHALL record the last requester granted (0=A, 1=B).
REQ-015 IDLE, only one request high: SHALL go to that requester's GNT state on the next edge.
REQ-016 IDLE, both requests high: SHALL grant the requester not equal to ULT (round robin).
REQ-017 IDLE, no request: SHALL remain IDLE; outputs hold.
REQ-018 On every grant edge (entry into GNT_x, including a direct switch): timer <= 0, ULT <= x, o_Datos1..4 <= i_Datos_x; grant and new digits SHALL appear in the same cycle.
REQ-019 In GNT_x: timer SHALL increment by 1 each cycle, saturating at T_MIN; hold is satisfied when timer == T_MIN.
REQ-020 In GNT_x with i_Req_x high: o_Datos1..4 SHALL reload from i_Datos_x every edge (one-cycle latency from input to display bus).
REQ-021 In GNT_x with i_Req_x low: o_Datos1..4 SHALL freeze at their last value.
REQ-022 In GNT_x before hold is satisfied: SHALL stay in GNT_x regardless of either request; grant is never revoked early.
REQ-023 GNT_x, hold satisfied, other request high: SHALL switch directly to GNT_other on that edge, with no IDLE cycle, regardless of i_Req_x (fairness).
REQ-024 GNT_x, hold satisfied, other request low, i_Req_x high: SHALL stay in GNT_x (timer saturated).
REQ-025 GNT_x, hold satisfied, both requests low: SHALL go to IDLE; o_Datos1..4 SHALL keep the last value shown.
REQ-026 Minimum grant length SHALL be T_MIN+1 cycles.
REQ-027 A requester released or preempted SHALL NOT be re-granted before the other requester has received a grant if both requests remain high.

Reset
REQ-028 When i_Rst is high at an edge: state <= IDLE, o_Gnt_A=o_Gnt_B=o_Ocupado=0, o_Datos1..4=4'h0, timer=0, ULT=1 (A wins first tie); this takes priority over all other behaviour.
REQ-029 Reset mid-grant SHALL abort the grant immediately; no state or timer value is carried over.

Verification (T_MIN=3)
REQ-030 Reset, then i_Req_A=1, i_Datos_A=16'h1234 -> next edge o_Gnt_A=1, o_Datos1..4=1,2,3,4, o_Ocupado=1.
REQ-031 Both requests raised together from reset -> A granted; A held 4 cycles; B granted on 5th edge with no gap; o_Datos=i_Datos_B same cycle.
REQ-032 A granted, i_Req_A dropped after 1 cycle, B idle -> o_Gnt_A stays high 4 cycles total, then IDLE; digits frozen at A's last sampled value.
REQ-033 A granted, i_Datos_A changes 16'h1234->16'h5678 mid-grant -> o_Datos shows 5,6,7,8 one cycle later.
REQ-034 B granted with both requests held continuously -> grants alternate B,A,B every 4 cycles; never both grants high.
REQ-035 i_Rst pulsed for one cycle during GNT_B -> next cycle all outputs 0, state IDLE; with both requests high, A is granted next.
